// File: rtl/dap_reg_cmd_master.sv
// dap_reg_cmd_master: turns a little-endian command byte stream into single
// register-bus writes/reads and answers with an ack byte, an error byte, or
// four read-data bytes (LSB first) on the response stream.
module dap_reg_cmd_master #(
  parameter int          ADDRWIDTH = 12,
  parameter logic [7:0]  ACK_BYTE  = 8'hA5,
  parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 mem_write_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_byte_strobe,
  input  logic [31:0]          mem_rdata,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_OP,
    ST_ADDR0,
    ST_ADDR1,
    ST_DATA,
    ST_EXEC,
    ST_RD_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  state_t                r_state;
  logic                  r_rw;
  logic [7:0]            r_addr_lo;
  logic [1:0]            r_cnt;
  logic [2:0]            r_remain;
  logic [31:0]           r_rd_shift;
  logic                  r_mem_write_en;
  logic [ADDRWIDTH-1:0]  r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_strb;
  logic [7:0]            r_m_tdata;
  logic                  r_m_tvalid;

  logic                  w_s_tready;
  logic                  w_s_accept;
  logic                  w_m_take;

  // Input is only taken while a frame byte is actually expected.
  assign w_s_tready = (r_state == ST_OP) || (r_state == ST_ADDR0) ||
                      (r_state == ST_ADDR1) || (r_state == ST_DATA);
  assign w_s_accept = s_tvalid && w_s_tready;
  assign w_m_take   = r_m_tvalid && m_tready;

  assign s_tready        = w_s_tready;
  assign busy            = (r_state != ST_OP);
  assign m_tdata         = r_m_tdata;
  assign m_tvalid        = r_m_tvalid;
  assign mem_write_en    = r_mem_write_en;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_strobe = r_mem_strb;

  // Frame parser, bus strobe and response sequencer in one state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_OP;
      r_rw           <= 1'b0;
      r_addr_lo      <= 8'h00;
      r_cnt          <= 2'd0;
      r_remain       <= 3'd0;
      r_rd_shift     <= 32'h0;
      r_mem_write_en <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= 32'h0;
      r_mem_strb     <= 4'h0;
      r_m_tdata      <= 8'h00;
      r_m_tvalid     <= 1'b0;
    end else begin
      case (r_state)
        ST_OP: begin
          if (w_s_accept) begin
            if (s_tdata[6:4] != 3'b000) begin
              r_state <= ST_ERR;
            end else begin
              r_rw       <= s_tdata[7];
              r_mem_strb <= s_tdata[3:0];
              r_state    <= ST_ADDR0;
            end
          end
        end
        ST_ADDR0: begin
          if (w_s_accept) begin
            r_addr_lo <= s_tdata;
            r_state   <= ST_ADDR1;
          end
        end
        ST_ADDR1: begin
          if (w_s_accept) begin
            // Upper address bits beyond the bus width are silently dropped.
            r_mem_addr <= ADDRWIDTH'({s_tdata, r_addr_lo});
            r_cnt      <= 2'd0;
            r_state    <= r_rw ? ST_DATA : ST_RD_WAIT;
          end
        end
        ST_DATA: begin
          if (w_s_accept) begin
            r_mem_wdata[{r_cnt, 3'b000} +: 8] <= s_tdata;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_mem_write_en <= 1'b1;
              r_state        <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_mem_write_en <= 1'b0;
          r_m_tdata      <= ACK_BYTE;
          r_m_tvalid     <= 1'b1;
          r_remain       <= 3'd1;
          r_state        <= ST_RESP;
        end
        ST_RD_WAIT: begin
          // mem_addr has been stable for a full cycle; slave data is settled.
          r_rd_shift <= mem_rdata;
          r_m_tdata  <= mem_rdata[7:0];
          r_m_tvalid <= 1'b1;
          r_remain   <= 3'd4;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (w_m_take) begin
            r_remain <= r_remain - 3'd1;
            if (r_remain == 3'd1) begin
              r_m_tvalid <= 1'b0;
              r_state    <= ST_OP;
            end else begin
              r_m_tdata  <= r_rd_shift[15:8];
              r_rd_shift <= r_rd_shift >> 8;
            end
          end
        end
        ST_ERR: begin
          r_m_tdata  <= ERR_BYTE;
          r_m_tvalid <= 1'b1;
          r_remain   <= 3'd1;
          r_state    <= ST_RESP;
        end
        default: r_state <= ST_OP;
      endcase
    end
  end

endmodule
